// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported 16x512 RAM between CPU fetch (IF) and memory stage (D).
// Optional perf counters are present only when MEM_PORT_ARBITER_PERF_EN is defined.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned CNT_W      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [8:0]  if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [8:0]  d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic [1:0]  mem_cmd,
  output logic [8:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [15:0] perf_conflict,
  output logic [15:0] perf_if_stall
`endif
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic             tag0_vld, tag0_d;
  logic             tag1_vld, tag1_d;

  // A limit of zero never matches, so D keeps priority forever.
  assign starve_hit = (STARVE_MAX != 0) && (starve_cnt == STARVE_LIM);

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (reset) begin
      if (if_req && d_req) begin
        if (starve_hit) if_gnt = 1'b1;
        else            d_gnt  = 1'b1;
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Address and write data hold their last value when no command is issued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_cmd   <= CMD_NONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (if_gnt) begin
      mem_cmd  <= CMD_RD;
      mem_addr <= if_addr;
    end else if (d_gnt) begin
      mem_cmd  <= d_we ? CMD_WR : CMD_RD;
      mem_addr <= d_addr;
      if (d_we) mem_wdata <= d_wdata;
    end else begin
      mem_cmd <= CMD_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tag0_vld <= 1'b0;
      tag0_d   <= 1'b0;
      tag1_vld <= 1'b0;
      tag1_d   <= 1'b0;
    end else begin
      tag0_vld <= if_gnt || (d_gnt && !d_we);
      tag0_d   <= d_gnt;
      tag1_vld <= tag0_vld;
      tag1_d   <= tag0_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= tag1_vld && !tag1_d;
      d_rvalid  <= tag1_vld && tag1_d;
      if (tag1_vld && !tag1_d) if_rdata <= mem_rdata;
      if (tag1_vld && tag1_d)  d_rdata  <= mem_rdata;
    end
  end

`ifdef MEM_PORT_ARBITER_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_conflict <= '0;
      perf_if_stall <= '0;
    end else begin
      if (if_req && d_req)   perf_conflict <= perf_conflict + 16'd1;
      if (if_req && !if_gnt) perf_if_stall <= perf_if_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [8:0]  if_addr, d_addr;
  logic [15:0] d_wdata;
  logic        if_gnt, d_gnt, if_rvalid, d_rvalid;
  logic [15:0] if_rdata, d_rdata;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [15:0] perf_conflict, perf_if_stall;
`endif

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_PORT_ARBITER_PERF_EN
    , .perf_conflict(perf_conflict), .perf_if_stall(perf_if_stall)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] init_val(input logic [8:0] a);
    case (a)
      9'h001:  init_val = 16'h1111;
      9'h002:  init_val = 16'h2222;
      9'h003:  init_val = 16'h3333;
      9'h005:  init_val = 16'hA5A5;
      default: init_val = (16'(a) * 16'h9E37) ^ 16'h5A5A;
    endcase
  endfunction

  // RAM: one-cycle read latency, write on command cycle
  logic [15:0] ram [512];
  initial begin
    mem_rdata = 16'h0000;
    for (int i = 0; i < 512; i++) ram[i] = init_val(9'(i));
    forever begin
      @(posedge clk);
      if (mem_cmd == 2'b01)      mem_rdata <= ram[mem_addr];
      else if (mem_cmd == 2'b10) ram[mem_addr] <= mem_wdata;
    end
  end

  // Reference model: reads return the value of the latest earlier-granted write, 3 cycles after grant.
  typedef struct { int due; bit is_d; logic [15:0] data; } rd_t;
  rd_t         m_q[$];
  rd_t         m_rd;
  logic [15:0] m_mem [512];
  int          m_cnt = 0;
  int          m_cyc = 0;
  logic [1:0]  m_cmd = 2'b00;
  logic [8:0]  m_addr = '0;
  logic [15:0] m_wdata = '0;
  bit          m_addr_chk = 1'b1;
  bit          m_wdata_chk = 1'b1;
  logic [15:0] m_if_rdata = '0;
  logic [15:0] m_d_rdata = '0;
  logic [15:0] m_conf = '0;
  logic [15:0] m_stall = '0;
  bit          e_if_v, e_d_v, e_gi, e_gd;

  initial begin
    for (int i = 0; i < 512; i++) m_mem[i] = init_val(9'(i));
    forever begin
      @(negedge clk);
      chk("mem_cmd", 32'(mem_cmd), 32'(m_cmd));
      if (m_addr_chk)  chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (m_wdata_chk) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));

      e_if_v = 1'b0;
      e_d_v  = 1'b0;
      if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
        m_rd = m_q.pop_front();
        if (m_rd.is_d) begin e_d_v = 1'b1; m_d_rdata = m_rd.data; end
        else begin e_if_v = 1'b1; m_if_rdata = m_rd.data; end
      end
      chk("if_rvalid", 32'(if_rvalid), 32'(e_if_v));
      chk("d_rvalid", 32'(d_rvalid), 32'(e_d_v));
      chk("if_rdata", 32'(if_rdata), 32'(m_if_rdata));
      chk("d_rdata", 32'(d_rdata), 32'(m_d_rdata));

      e_gi = 1'b0;
      e_gd = 1'b0;
      if (reset) begin
        if (if_req && d_req) begin
          if (STARVE_MAX != 0 && m_cnt == STARVE_MAX) e_gi = 1'b1;
          else e_gd = 1'b1;
        end else begin
          e_gi = if_req;
          e_gd = d_req;
        end
      end
      chk("if_gnt", 32'(if_gnt), 32'(e_gi));
      chk("d_gnt", 32'(d_gnt), 32'(e_gd));

`ifdef MEM_PORT_ARBITER_PERF_EN
      chk("perf_conflict", 32'(perf_conflict), 32'(m_conf));
      chk("perf_if_stall", 32'(perf_if_stall), 32'(m_stall));
`endif

      if (!reset) begin
        m_cnt = 0; m_cmd = 2'b00; m_addr = '0; m_wdata = '0;
        m_addr_chk = 1'b1; m_wdata_chk = 1'b1;
        m_if_rdata = '0; m_d_rdata = '0;
        m_conf = '0; m_stall = '0;
        m_q.delete();
      end else begin
        if (if_req && d_req) m_conf = m_conf + 16'd1;
        if (if_req && !e_gi) m_stall = m_stall + 16'd1;
        if (!if_req || e_gi) m_cnt = 0;
        else if (m_cnt < STARVE_MAX) m_cnt = m_cnt + 1;
        m_wdata_chk = 1'b0;
        if (e_gi) begin
          m_cmd = 2'b01; m_addr = if_addr; m_addr_chk = 1'b1;
          m_q.push_back('{due: m_cyc + 3, is_d: 1'b0, data: m_mem[if_addr]});
        end else if (e_gd) begin
          m_addr = d_addr; m_addr_chk = 1'b1;
          if (d_we) begin
            m_cmd = 2'b10; m_wdata = d_wdata; m_wdata_chk = 1'b1;
            m_mem[d_addr] = d_wdata;
          end else begin
            m_cmd = 2'b01;
            m_q.push_back('{due: m_cyc + 3, is_d: 1'b1, data: m_mem[d_addr]});
          end
        end else begin
          m_cmd = 2'b00; m_addr_chk = 1'b0;
        end
      end
      m_cyc++;
    end
  end

  bit g_if, g_d;

  initial begin
    reset = 1'b0; if_req = 1'b1; if_addr = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    repeat (2) begin
      @(negedge clk);
      chk("rst_if_gnt", 32'(if_gnt), 0);
      chk("rst_d_gnt", 32'(d_gnt), 0);
      chk("rst_mem_cmd", 32'(mem_cmd), 0);
      chk("rst_rvalid", 32'({if_rvalid, d_rvalid}), 0);
      chk("rst_rdata", 32'({if_rdata, d_rdata}), 0);
    end
    tick(); if_req = 1'b0; d_req = 1'b0;
    tick(); reset = 1'b1;

    // single IF read
    tick(); if_req = 1'b1; if_addr = 9'h005;
    @(negedge clk); chk("ifrd_gnt", 32'({if_gnt, d_gnt}), 32'b10);
    tick(); if_req = 1'b0;
    @(negedge clk); chk("ifrd_cmd", 32'(mem_cmd), 1); chk("ifrd_addr", 32'(mem_addr), 5);
    chk("ifrd_early", 32'(if_rvalid), 0);
    tick(); @(negedge clk); chk("ifrd_early", 32'(if_rvalid), 0);
    tick(); @(negedge clk); chk("ifrd_rvalid", 32'(if_rvalid), 1);
    chk("ifrd_data", 32'(if_rdata), 32'h0000A5A5);
    tick(); @(negedge clk); chk("ifrd_pulse", 32'(if_rvalid), 0);

    // conflict with a store
    tick(); if_req = 1'b1; if_addr = 9'h020;
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h010; d_wdata = 16'h1234;
    @(negedge clk); chk("conf_gnt", 32'({if_gnt, d_gnt}), 32'b01);
    tick(); d_req = 1'b0; d_we = 1'b0;
    @(negedge clk); chk("conf_if_gnt", 32'(if_gnt), 1);
    chk("conf_cmd", 32'(mem_cmd), 2); chk("conf_addr", 32'(mem_addr), 32'h10);
    chk("conf_wdata", 32'(mem_wdata), 32'h1234);
    tick(); if_req = 1'b0;
    repeat (4) tick();

    // starvation with both requesters reading continuously
    if_req = 1'b1; if_addr = 9'h030; d_req = 1'b1; d_we = 1'b0; d_addr = 9'h040;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      g_if = if_gnt; g_d = d_gnt;
      chk("starve_if_gnt", 32'(g_if), 32'(k == 3));
      chk("starve_d_gnt", 32'(g_d), 32'(k != 3));
      tick();
      if (g_d) d_addr = d_addr + 9'd1;
      if (k == 4) d_req = 1'b0;
    end
    @(negedge clk); chk("starve_tail", 32'(if_gnt), 1);
    tick(); if_req = 1'b0;
    repeat (4) tick();

    // interleaved reads
    if_req = 1'b1; if_addr = 9'h001;
    @(negedge clk); chk("il_gnt0", 32'(if_gnt), 1);
    tick(); if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 9'h002;
    @(negedge clk); chk("il_gnt1", 32'(d_gnt), 1);
    tick(); d_req = 1'b0; if_req = 1'b1; if_addr = 9'h003;
    @(negedge clk); chk("il_gnt2", 32'(if_gnt), 1);
    tick(); if_req = 1'b0;
    @(negedge clk); chk("il_rv0", 32'({if_rvalid, d_rvalid}), 32'b10);
    chk("il_data0", 32'(if_rdata), 32'h1111);
    tick(); @(negedge clk); chk("il_rv1", 32'({if_rvalid, d_rvalid}), 32'b01);
    chk("il_data1", 32'(d_rdata), 32'h2222); chk("il_hold_if", 32'(if_rdata), 32'h1111);
    tick(); @(negedge clk); chk("il_rv2", 32'({if_rvalid, d_rvalid}), 32'b10);
    chk("il_data2", 32'(if_rdata), 32'h3333); chk("il_hold_d", 32'(d_rdata), 32'h2222);

    // store then load of the same address
    tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 9'h050; d_wdata = 16'hBEEF;
    @(negedge clk); chk("raw_wgnt", 32'(d_gnt), 1);
    tick(); d_we = 1'b0;
    @(negedge clk); chk("raw_rgnt", 32'(d_gnt), 1);
    tick(); d_req = 1'b0;
    repeat (2) tick();
    @(negedge clk); chk("raw_rvalid", 32'(d_rvalid), 1); chk("raw_data", 32'(d_rdata), 32'hBEEF);

    // reset while a read is in flight
    tick(); if_req = 1'b1; if_addr = 9'h005;
    @(negedge clk); chk("rif_gnt", 32'(if_gnt), 1);
    tick(); if_req = 1'b0;
    tick(); reset = 1'b0;
    tick(); reset = 1'b1;
    @(negedge clk); chk("rif_rvalid", 32'(if_rvalid), 0); chk("rif_cmd", 32'(mem_cmd), 0);

    // randomized traffic; requests are held until granted
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      g_if = if_gnt; g_d = d_gnt;
      tick();
      if (!if_req || g_if) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = 9'($urandom_range(0, 15));
      end
      if (!d_req || g_d) begin
        d_req   = ($urandom_range(0, 99) < 60);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = 9'($urandom_range(0, 15));
        d_wdata = 16'($urandom());
      end
      reset = ($urandom_range(0, 299) != 0);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
